// File: rtl/opcode_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : common_types (package)
// Purpose  : Shared types for the 6502 opcode decoder: data/address words,
//            mnemonic and addressing-mode enums, and the mode-to-length helper.
// Revision : 1.0 - initial release
// ============================================================================
package common_types;

    typedef logic [7:0]  data_t;
    typedef logic [15:0] addr_t;

    // The 56 official mnemonics in alphabetical order, followed by ILL.
    typedef enum logic [5:0] {
        ADC, AND, ASL, BCC, BCS, BEQ, BIT, BMI, BNE, BPL, BRK, BVC, BVS,
        CLC, CLD, CLI, CLV, CMP, CPX, CPY, DEC, DEX, DEY, EOR, INC, INX,
        INY, JMP, JSR, LDA, LDX, LDY, LSR, NOP, ORA, PHA, PHP, PLA, PLP,
        ROL, ROR, RTI, RTS, SBC, SEC, SED, SEI, STA, STX, STY, TAX, TAY,
        TSX, TXA, TXS, TYA, ILL
    } opc_t;

    typedef enum logic [3:0] {
        IMP, ACC, IMM, ZP, ZPX, ZPY, ABS, ABSX, ABSY, IND, INDX, INDY, REL
    } addmod_t;

    // Total instruction length (opcode byte plus operand bytes) for a mode.
    function automatic logic [1:0] mode_len(input addmod_t m);
        logic [1:0] r_len;
        case (m)
            IMP, ACC:              r_len = 2'd1;
            ABS, ABSX, ABSY, IND:  r_len = 2'd3;
            default:               r_len = 2'd2;
        endcase
        return r_len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/opcode_decode_lut.sv
`default_nettype none
// ============================================================================
// Module   : opcode_lut
// Purpose  : Combinational 6502 opcode classifier (byte -> mnemonic, mode).
//            Decodes the regular aaabbbcc field structure and patches the
//            irregular entries. Undocumented bytes yield NOP/IMP, or ILL/IMP
//            when DECODE_ILLEGAL_TRAP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module opcode_lut
    import common_types::*;
(
    input  data_t   instr_i,
    output opc_t    opcode_o,
    output addmod_t mode_o
);

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam opc_t c_undoc_opc = ILL;
`else
    localparam opc_t c_undoc_opc = NOP;
`endif

    logic [2:0] w_aaa;
    logic [2:0] w_bbb;
    logic [1:0] w_cc;
    logic       w_legal;
    opc_t       w_opc;
    addmod_t    w_mode;

    assign w_aaa = instr_i[7:5];
    assign w_bbb = instr_i[4:2];
    assign w_cc  = instr_i[1:0];

    // cc=01: accumulator ALU group.
    function automatic opc_t alu_opc(input logic [2:0] a);
        opc_t r;
        case (a)
            3'b000:  r = ORA;
            3'b001:  r = AND;
            3'b010:  r = EOR;
            3'b011:  r = ADC;
            3'b100:  r = STA;
            3'b101:  r = LDA;
            3'b110:  r = CMP;
            default: r = SBC;
        endcase
        return r;
    endfunction

    // cc=10: read-modify-write and X-register group.
    function automatic opc_t rmw_opc(input logic [2:0] a);
        opc_t r;
        case (a)
            3'b000:  r = ASL;
            3'b001:  r = ROL;
            3'b010:  r = LSR;
            3'b011:  r = ROR;
            3'b100:  r = STX;
            3'b101:  r = LDX;
            3'b110:  r = DEC;
            default: r = INC;
        endcase
        return r;
    endfunction

    // cc=00: control / Y-register group with operands.
    function automatic opc_t ctl_opc(input logic [2:0] a);
        opc_t r;
        case (a)
            3'b001:  r = BIT;
            3'b010:  r = JMP;
            3'b011:  r = JMP;
            3'b100:  r = STY;
            3'b101:  r = LDY;
            3'b110:  r = CPY;
            3'b111:  r = CPX;
            default: r = ILL;
        endcase
        return r;
    endfunction

    // xxx10000: conditional branches, selected by flag and sense.
    function automatic opc_t br_opc(input logic [2:0] a);
        opc_t r;
        case (a)
            3'b000:  r = BPL;
            3'b001:  r = BMI;
            3'b010:  r = BVC;
            3'b011:  r = BVS;
            3'b100:  r = BCC;
            3'b101:  r = BCS;
            3'b110:  r = BNE;
            default: r = BEQ;
        endcase
        return r;
    endfunction

    // xxx01000: stack and register single-byte instructions.
    function automatic opc_t imp08_opc(input logic [2:0] a);
        opc_t r;
        case (a)
            3'b000:  r = PHP;
            3'b001:  r = PLP;
            3'b010:  r = PHA;
            3'b011:  r = PLA;
            3'b100:  r = DEY;
            3'b101:  r = TAY;
            3'b110:  r = INY;
            default: r = INX;
        endcase
        return r;
    endfunction

    // xxx11000: flag instructions plus TYA.
    function automatic opc_t imp18_opc(input logic [2:0] a);
        opc_t r;
        case (a)
            3'b000:  r = CLC;
            3'b001:  r = SEC;
            3'b010:  r = CLI;
            3'b011:  r = SEI;
            3'b100:  r = TYA;
            3'b101:  r = CLV;
            3'b110:  r = CLD;
            default: r = SED;
        endcase
        return r;
    endfunction

    // Field decode with per-opcode overrides; w_legal marks official opcodes.
    always_comb begin
        w_legal = 1'b0;
        w_opc   = NOP;
        w_mode  = IMP;
        case (w_cc)
            2'b01: begin
                w_opc   = alu_opc(w_aaa);
                w_legal = (instr_i != 8'h89);      // no STA immediate
                case (w_bbb)
                    3'b000:  w_mode = INDX;
                    3'b001:  w_mode = ZP;
                    3'b010:  w_mode = IMM;
                    3'b011:  w_mode = ABS;
                    3'b100:  w_mode = INDY;
                    3'b101:  w_mode = ZPX;
                    3'b110:  w_mode = ABSY;
                    default: w_mode = ABSX;
                endcase
            end
            2'b10: begin
                w_opc = rmw_opc(w_aaa);
                case (w_bbb)
                    3'b000: begin                  // only LDX #imm
                        w_legal = (w_aaa == 3'b101);
                        w_mode  = IMM;
                    end
                    3'b001: begin
                        w_legal = 1'b1;
                        w_mode  = ZP;
                    end
                    3'b010: begin
                        w_legal = 1'b1;
                        if (!w_aaa[2]) begin
                            w_mode = ACC;          // shifts/rotates on A
                        end else begin
                            w_mode = IMP;
                            case (w_aaa[1:0])
                                2'b00:   w_opc = TXA;
                                2'b01:   w_opc = TAX;
                                2'b10:   w_opc = DEX;
                                default: w_opc = NOP;
                            endcase
                        end
                    end
                    3'b011: begin
                        w_legal = 1'b1;
                        w_mode  = ABS;
                    end
                    3'b101: begin                  // STX/LDX index with Y
                        w_legal = 1'b1;
                        w_mode  = (w_aaa[2:1] == 2'b10) ? ZPY : ZPX;
                    end
                    3'b110: begin
                        w_mode = IMP;
                        if (w_aaa == 3'b100) begin
                            w_legal = 1'b1;
                            w_opc   = TXS;
                        end else if (w_aaa == 3'b101) begin
                            w_legal = 1'b1;
                            w_opc   = TSX;
                        end
                    end
                    3'b111: begin                  // no STX abs,Y
                        w_legal = (w_aaa != 3'b100);
                        w_mode  = (w_aaa == 3'b101) ? ABSY : ABSX;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            2'b00: begin
                w_opc = ctl_opc(w_aaa);
                case (w_bbb)
                    3'b000: begin
                        w_legal = (w_aaa != 3'b100);
                        case (w_aaa)
                            3'b000:  begin w_opc = BRK; w_mode = IMP; end
                            3'b001:  begin w_opc = JSR; w_mode = ABS; end
                            3'b010:  begin w_opc = RTI; w_mode = IMP; end
                            3'b011:  begin w_opc = RTS; w_mode = IMP; end
                            default: w_mode = IMM;
                        endcase
                    end
                    3'b001: begin
                        w_legal = (w_aaa == 3'b001) || w_aaa[2];
                        w_mode  = ZP;
                    end
                    3'b010: begin
                        w_legal = 1'b1;
                        w_opc   = imp08_opc(w_aaa);
                        w_mode  = IMP;
                    end
                    3'b011: begin                  // 0x6C is the indirect JMP
                        w_legal = (w_aaa != 3'b000);
                        w_mode  = (w_aaa == 3'b011) ? IND : ABS;
                    end
                    3'b100: begin
                        w_legal = 1'b1;
                        w_opc   = br_opc(w_aaa);
                        w_mode  = REL;
                    end
                    3'b101: begin
                        w_legal = (w_aaa[2:1] == 2'b10);
                        w_mode  = ZPX;
                    end
                    3'b110: begin
                        w_legal = 1'b1;
                        w_opc   = imp18_opc(w_aaa);
                        w_mode  = IMP;
                    end
                    default: begin
                        w_legal = (w_aaa == 3'b101);
                        w_mode  = ABSX;
                    end
                endcase
            end
            default: w_legal = 1'b0;               // cc=11 is never official
        endcase
    end

    assign opcode_o = w_legal ? w_opc  : c_undoc_opc;
    assign mode_o   = w_legal ? w_mode : IMP;

endmodule
`default_nettype wire

// File: rtl/opcode_decode.sv
`default_nettype none
// ============================================================================
// Module   : opcode_decode
// Purpose  : Registered 6502 instruction decoder. One-cycle latency from an
//            accepted opcode byte to mnemonic/mode/length with out_valid.
//            Outputs hold while no byte is offered. Undocumented-opcode
//            handling follows DECODE_ILLEGAL_TRAP_EN (see opcode_lut).
// Revision : 1.0 - initial release
// ============================================================================
module opcode_decode
    import common_types::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  data_t      instr,
    output opc_t       opcode,
    output addmod_t    mode,
    output logic [1:0] len,
    output logic       out_valid
);

    opc_t       w_lut_opc;
    addmod_t    w_lut_mode;

    opc_t       opcode_d,    opcode_q;
    addmod_t    mode_d,      mode_q;
    logic [1:0] len_d,       len_q;
    logic       out_valid_d, out_valid_q;

    opcode_lut u_lut (
        .instr_i  (instr),
        .opcode_o (w_lut_opc),
        .mode_o   (w_lut_mode)
    );

    // Load a fresh decode on a valid byte, otherwise hold the last result.
    always_comb begin
        opcode_d    = opcode_q;
        mode_d      = mode_q;
        len_d       = len_q;
        out_valid_d = instr_valid;
        if (instr_valid) begin
            opcode_d = w_lut_opc;
            mode_d   = w_lut_mode;
            len_d    = mode_len(w_lut_mode);
        end
    end

    // Output registers; reset forces the NOP/IMP/1 idle decode immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q    <= NOP;
            mode_q      <= IMP;
            len_q       <= 2'd1;
            out_valid_q <= 1'b0;
        end else begin
            opcode_q    <= opcode_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign opcode    = opcode_q;
    assign mode      = mode_q;
    assign len       = len_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_opcode_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_opcode_decode
// Purpose  : Self-checking bench for opcode_decode. A golden 6502 opcode
//            table feeds a scoreboard queue; a monitor pops and compares each
//            result one cycle after its byte is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module tb_opcode_decode;
    import common_types::*;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam opc_t c_undoc     = ILL;
    localparam int   c_undoc_cnt = 105;
`else
    localparam opc_t c_undoc     = NOP;
    localparam int   c_undoc_cnt = 106;   // 105 undocumented plus 0xEA
`endif

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b0;
    logic       instr_valid = 1'b0;
    data_t      instr       = 8'h00;
    opc_t       opcode;
    addmod_t    mode;
    logic [1:0] len;
    logic       out_valid;

    opcode_decode dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .opcode      (opcode),
        .mode        (mode),
        .len         (len),
        .out_valid   (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        logic [15:0] exp;
    } sb_t;

    sb_t     sb_q[$];
    int      n_cmp    = 0;
    int      n_err    = 0;
    int      n_undoc  = 0;
    logic    sweep_on = 1'b0;
    opc_t    g_opc  [256];
    addmod_t g_mode [256];
    logic    mon_s;
    sb_t     mon_e;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] len_of(input addmod_t m);
        case (m)
            IMP, ACC:             return 2'd1;
            IMM, ZP, ZPX, ZPY,
            INDX, INDY, REL:      return 2'd2;
            default:              return 2'd3;
        endcase
    endfunction

    function automatic logic [15:0] exp_of(input logic [7:0] b);
        return {4'b0, g_opc[b], g_mode[b], len_of(g_mode[b])};
    endfunction

    function automatic logic [15:0] tuple(input opc_t o, input addmod_t m, input logic [1:0] l);
        return {4'b0, o, m, l};
    endfunction

    task automatic t(input logic [7:0] b, input opc_t o, input addmod_t m);
        g_opc[b]  = o;
        g_mode[b] = m;
    endtask

    // Standard column layout of the accumulator ALU rows.
    task automatic alu(input logic [7:0] base, input opc_t o);
        t(base + 8'h00, o, INDX); t(base + 8'h04, o, ZP);
        t(base + 8'h08, o, IMM);  t(base + 8'h0C, o, ABS);
        t(base + 8'h10, o, INDY); t(base + 8'h14, o, ZPX);
        t(base + 8'h18, o, ABSY); t(base + 8'h1C, o, ABSX);
    endtask

    task automatic build_table();
        for (int i = 0; i < 256; i++) begin
            g_opc[i]  = c_undoc;
            g_mode[i] = IMP;
        end
        alu(8'h01, ORA); alu(8'h21, AND); alu(8'h41, EOR); alu(8'h61, ADC);
        alu(8'hA1, LDA); alu(8'hC1, CMP); alu(8'hE1, SBC);
        t(8'h81, STA, INDX); t(8'h85, STA, ZP);   t(8'h8D, STA, ABS);  t(8'h91, STA, INDY);
        t(8'h95, STA, ZPX);  t(8'h99, STA, ABSY); t(8'h9D, STA, ABSX);
        t(8'h06, ASL, ZP);  t(8'h0A, ASL, ACC); t(8'h0E, ASL, ABS); t(8'h16, ASL, ZPX); t(8'h1E, ASL, ABSX);
        t(8'h26, ROL, ZP);  t(8'h2A, ROL, ACC); t(8'h2E, ROL, ABS); t(8'h36, ROL, ZPX); t(8'h3E, ROL, ABSX);
        t(8'h46, LSR, ZP);  t(8'h4A, LSR, ACC); t(8'h4E, LSR, ABS); t(8'h56, LSR, ZPX); t(8'h5E, LSR, ABSX);
        t(8'h66, ROR, ZP);  t(8'h6A, ROR, ACC); t(8'h6E, ROR, ABS); t(8'h76, ROR, ZPX); t(8'h7E, ROR, ABSX);
        t(8'h86, STX, ZP);  t(8'h8E, STX, ABS); t(8'h96, STX, ZPY);
        t(8'hA2, LDX, IMM); t(8'hA6, LDX, ZP);  t(8'hAE, LDX, ABS); t(8'hB6, LDX, ZPY); t(8'hBE, LDX, ABSY);
        t(8'hC6, DEC, ZP);  t(8'hCE, DEC, ABS); t(8'hD6, DEC, ZPX); t(8'hDE, DEC, ABSX);
        t(8'hE6, INC, ZP);  t(8'hEE, INC, ABS); t(8'hF6, INC, ZPX); t(8'hFE, INC, ABSX);
        t(8'h8A, TXA, IMP); t(8'h9A, TXS, IMP); t(8'hAA, TAX, IMP); t(8'hBA, TSX, IMP);
        t(8'hCA, DEX, IMP); t(8'hEA, NOP, IMP);
        t(8'h00, BRK, IMP); t(8'h20, JSR, ABS); t(8'h40, RTI, IMP); t(8'h60, RTS, IMP);
        t(8'h24, BIT, ZP);  t(8'h2C, BIT, ABS); t(8'h4C, JMP, ABS); t(8'h6C, JMP, IND);
        t(8'h84, STY, ZP);  t(8'h8C, STY, ABS); t(8'h94, STY, ZPX);
        t(8'hA0, LDY, IMM); t(8'hA4, LDY, ZP);  t(8'hAC, LDY, ABS); t(8'hB4, LDY, ZPX); t(8'hBC, LDY, ABSX);
        t(8'hC0, CPY, IMM); t(8'hC4, CPY, ZP);  t(8'hCC, CPY, ABS);
        t(8'hE0, CPX, IMM); t(8'hE4, CPX, ZP);  t(8'hEC, CPX, ABS);
        t(8'h10, BPL, REL); t(8'h30, BMI, REL); t(8'h50, BVC, REL); t(8'h70, BVS, REL);
        t(8'h90, BCC, REL); t(8'hB0, BCS, REL); t(8'hD0, BNE, REL); t(8'hF0, BEQ, REL);
        t(8'h08, PHP, IMP); t(8'h28, PLP, IMP); t(8'h48, PHA, IMP); t(8'h68, PLA, IMP);
        t(8'h88, DEY, IMP); t(8'hA8, TAY, IMP); t(8'hC8, INY, IMP); t(8'hE8, INX, IMP);
        t(8'h18, CLC, IMP); t(8'h38, SEC, IMP); t(8'h58, CLI, IMP); t(8'h78, SEI, IMP);
        t(8'h98, TYA, IMP); t(8'hB8, CLV, IMP); t(8'hD8, CLD, IMP); t(8'hF8, SED, IMP);
    endtask

    // Present one byte at the falling edge; accepted bytes enter the scoreboard.
    task automatic drive(input logic [7:0] byte_i, input logic v);
        sb_t e;
        @(negedge clk);
        instr       = byte_i;
        instr_valid = v;
        if (v && rst_n) begin
            e.b   = byte_i;
            e.exp = exp_of(byte_i);
            sb_q.push_back(e);
        end
    endtask

    // Monitor: out_valid must follow the accepted-byte sample one cycle later.
    always @(posedge clk) begin
        mon_s = instr_valid & rst_n;
        #1;
        check("out_valid", {15'b0, out_valid}, {15'b0, mon_s});
        if (mon_s && sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check($sformatf("decode_%02h", mon_e.b), {4'b0, opcode, mode, len}, mon_e.exp);
            if (sweep_on && opcode == c_undoc && mode == IMP && len == 2'd1)
                n_undoc++;
        end
    end

    initial begin
        build_table();

        // Reset state while rst_n is held low.
        repeat (2) @(posedge clk);
        #2;
        check("reset_tuple", {4'b0, opcode, mode, len}, tuple(NOP, IMP, 2'd1));
        check("reset_valid", {15'b0, out_valid}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First byte after reset, then a back-to-back stream.
        drive(8'hA2, 1'b1);
        drive(8'hA6, 1'b1); drive(8'h4C, 1'b1); drive(8'hE8, 1'b1); drive(8'h6C, 1'b1);

        // Y-index exceptions and anchors.
        drive(8'hB6, 1'b1); drive(8'hBE, 1'b1); drive(8'h96, 1'b1); drive(8'hB1, 1'b1);
        drive(8'hA1, 1'b1); drive(8'h00, 1'b1); drive(8'hEA, 1'b1); drive(8'h20, 1'b1);
        drive(8'h02, 1'b1); drive(8'hFF, 1'b1);
        drive(8'h00, 1'b0);

        // Full 256-byte sweep against the golden table.
        sweep_on = 1'b1;
        for (int i = 0; i < 256; i++) drive(8'(i), 1'b1);
        drive(8'h00, 1'b0);
        @(posedge clk);
        #2;
        sweep_on = 1'b0;
        check("undoc_count", 16'(n_undoc), 16'(c_undoc_cnt));

        // Hold behaviour with instr_valid low and garbage on instr.
        drive(8'h0A, 1'b1);
        drive(8'hFF, 1'b0);
        @(posedge clk);
        #2;
        check("hold_tuple_1", {4'b0, opcode, mode, len}, tuple(ASL, ACC, 2'd1));
        drive(8'h20, 1'b0);
        @(posedge clk);
        #2;
        check("hold_tuple_2", {4'b0, opcode, mode, len}, tuple(ASL, ACC, 2'd1));

        // Asynchronous reset concurrent with a valid JSR byte.
        drive(8'h4C, 1'b1);
        @(negedge clk);
        instr       = 8'h20;
        instr_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tuple", {4'b0, opcode, mode, len}, tuple(NOP, IMP, 2'd1));
        check("async_rst_valid", {15'b0, out_valid}, 16'd0);
        @(posedge clk);
        #2;
        check("rst_discard_tuple", {4'b0, opcode, mode, len}, tuple(NOP, IMP, 2'd1));
        @(negedge clk);
        rst_n       = 1'b1;
        instr_valid = 1'b0;
        @(posedge clk);
        #2;
        check("post_rst_tuple", {4'b0, opcode, mode, len}, tuple(NOP, IMP, 2'd1));

        // Stream resumes after reset release.
        drive(8'h20, 1'b1);
        drive(8'hF0, 1'b1);
        drive(8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        check("sb_drained", 16'(sb_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
